// File: rtl/t_ff_using_d_d_ff_sync.sv
// WIDTH-wide D register with synchronous active-high reset to a parameterised value.
module d_ff_sync #(
    parameter int unsigned           WIDTH       = 1,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/t_ff_using_d.sv
// Vector of independent toggle flip-flops: D register fed with data ^ Q,
// complementary output derived combinationally from the stored state.
module t_ff_using_d #(
    parameter int unsigned           WIDTH       = 1,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qb
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = data ^ q_q;
    end

    d_ff_sync #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_reg (
        .clk (clk),
        .rst (rst),
        .d   (q_d),
        .q   (q_q)
    );

    assign Q  = q_q;
    assign Qb = ~q_q;

endmodule

// File: tb/tb_t_ff_using_d.sv
// Bench for t_ff_using_d: a default 1-bit instance and a 4-bit instance with a
// non-zero reset value, checked against a per-edge toggle reference model.
module tb_t_ff_using_d;

    logic       clk = 1'b0;
    logic       rst1;
    logic [0:0] data1;
    logic [0:0] q1;
    logic [0:0] qb1;
    logic       rst4;
    logic [3:0] data4;
    logic [3:0] q4;
    logic [3:0] qb4;

    logic [0:0] m1;
    logic [3:0] m4;
    int         checks   = 0;
    int         failures = 0;

    localparam logic [3:0] RV4 = 4'b1010;

    always #10 clk = ~clk;

    t_ff_using_d u_dut1 (
        .clk  (clk),
        .rst  (rst1),
        .data (data1),
        .Q    (q1),
        .Qb   (qb1)
    );

    t_ff_using_d #(
        .WIDTH       (4),
        .RESET_VALUE (RV4)
    ) u_dut4 (
        .clk  (clk),
        .rst  (rst4),
        .data (data4),
        .Q    (q4),
        .Qb   (qb4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".Q1"},  {31'd0, q1},  {31'd0, m1});
        check({tag, ".Qb1"}, {31'd0, qb1}, {31'd0, ~m1});
        check({tag, ".Q4"},  {28'd0, q4},  {28'd0, m4});
        check({tag, ".Qb4"}, {28'd0, qb4}, {28'd0, ~m4});
    endtask

    // Drive on the falling edge, advance the model at the rising edge, sample 1 later.
    task automatic step(input string tag, input logic r1, input logic d1,
                        input logic r4, input logic [3:0] d4);
        @(negedge clk);
        rst1  = r1;
        data1 = d1;
        rst4  = r4;
        data4 = d4;
        @(posedge clk);
        m1 = r1 ? 1'b0 : (m1 ^ d1);
        m4 = r4 ? RV4  : (m4 ^ d4);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst1  = 1'b0;
        data1 = 1'b0;
        rst4  = 1'b0;
        data4 = 4'd0;
        m1    = 1'b0;
        m4    = 4'd0;

        step("reset",      1'b1, 1'b0, 1'b1, 4'b0000);
        step("hold0",      1'b0, 1'b0, 1'b0, 4'b0110);
        step("toggle1",    1'b0, 1'b1, 1'b0, 4'b0000);
        step("hold1",      1'b0, 1'b0, 1'b0, 4'b1111);
        for (int i = 0; i < 4; i++) begin
            step("div2",   1'b0, 1'b1, 1'b0, 4'b1111);
        end
        step("rst_prio",   1'b1, 1'b1, 1'b1, 4'b1111);
        step("resume",     1'b0, 1'b1, 1'b0, 4'b0110);

        // Reset rises between edges: state must not move until the next rising edge.
        rst4  = 1'b1;
        data4 = 4'b0101;
        #4;
        check("midcycle_rst.Q4", {28'd0, q4}, {28'd0, m4});
        check("midcycle_rst.Qb4", {28'd0, qb4}, {28'd0, ~m4});
        step("midcycle_edge", 1'b0, 1'b0, 1'b1, 4'b0101);
        // Reset falls between edges: still no asynchronous effect.
        @(negedge clk);
        rst4  = 1'b0;
        data4 = 4'b0000;
        #3;
        rst4  = 1'b1;
        #3;
        rst4  = 1'b0;
        check("midcycle_pulse.Q4", {28'd0, q4}, {28'd0, m4});
        step("after_pulse", 1'b0, 1'b0, 1'b0, 4'b0011);

        for (int i = 0; i < 200; i++) begin
            step("rand",
                 ($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0),
                 4'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/t_ff_using_d.md
Name: t_ff_using_d

Overview:
- Toggle (T) flip-flop built from a D-type storage element plus next-state logic, D = T xor Q.
- Provides true and complementary outputs.
- General-purpose leaf cell for dividers, toggle counters and parity trackers; single clock domain.
- Parameterised width so one instance can hold a vector of independent toggle bits. Default width is 1.

Parameters:
- WIDTH, 1, number of independent toggle bits; each bit i of data controls bit i of Q.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into Q on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- data  input  WIDTH  toggle enable (T input); 1 = invert that bit on the next rising edge, 0 = hold.
- Q  output  WIDTH  registered state.
- Qb  output  WIDTH  bitwise complement of Q.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. No asynchronous reset path; rst has no effect between clock edges.
- Rising edge with rst=1: Q <= RESET_VALUE, so Q=0 and Qb=1 for the default. data is ignored.
- Rising edge with rst=0: Q <= Q ^ data, per bit.
  - data bit 1: that bit toggles.
  - data bit 0: that bit holds.
- Qb is combinational: Qb = ~Q at all times, with no extra register and no skew cycle.
- Latency: a change on data takes effect at the first rising edge at which it is sampled. Q updates only at rising edges; there is no combinational path from data to Q or Qb.
- Before the first reset edge, Q and Qb are unknown (X in simulation). No initial-value reliance; software or bench must apply reset first.
- rst=1 and data=1 on the same edge: reset wins.
- Reset asserted mid-sequence: the next edge forces RESET_VALUE regardless of history. Toggling resumes on the first edge after rst returns low.
- data held at 1 continuously: Q toggles every cycle, a divide-by-2 of clk. Output period is 2 clk periods.
- Inputs must be stable around the rising edge. The bench drives them on the falling edge.
- Storage: implemented as a D register (d_in = rst ? RESET_VALUE : data ^ Q). No latches.

Decomposition:
- No shared package is needed. RESET_VALUE and WIDTH are local parameters of the block.
- One natural sub-module: d_ff_sync, a WIDTH-wide D register with synchronous active-high reset to a parameterised value.
  - d_ff_sync ports: clk, rst, d, q.
  - Top level supplies d = data ^ q and drives Q = q, Qb = ~q.

Test Plan:
- Clock period 20 time units; stimulus on negedge. Assert rst=1 for one edge with data=0 -> after the edge Q=0, Qb=1.
- Release rst, data=0 for one edge -> Q stays 0, Qb=1.
- data=1 for one edge -> Q=1, Qb=0. Then data=0 for one edge -> Q holds 1, Qb=0.
- data=1 held for 4 edges from Q=1 -> Q sequence 0,1,0,1 and Qb always ~Q (divide-by-2 check).
- With Q=1, drive rst=1 and data=1 on the same edge -> Q=0, Qb=1 (reset priority). Release rst with data=1 -> Q=1 on the next edge.
- WIDTH=4, RESET_VALUE=4'b1010: reset, then data=4'b0110 for one edge -> Q=4'b1100, Qb=4'b0011. Check rst changed between edges does not alter Q until the next rising edge.
